imem_resp_unit: RTL and testbench
=================================

# imem_resp_unit

Latency-configurable memory responder: the far end of the processor's 4-byte memory request/response stream. It accepts requests over a val/rdy handshake, reads or writes an internal word array, and returns responses in order after a fixed latency. It sits opposite the datapath's imem/dmem ports in unit and integration benches, and serves as the behavioural memory in the processor test harness.

## Interface
- p_latency, 1, cycles from request accept to response valid (≥1)
- p_nwords_log, 8, log2 of array depth in 32-bit words
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_type  in  3  0=read, 1=write, 2=init
- req_opaque  in  8  tag, echoed in response
- req_addr  in  32  byte address
- req_len  in  2  bytes; 0 means 4
- req_data  in  32  write data, LSB-aligned
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_type  out  3  copy of req_type
- resp_opaque  out  8  copy of req_opaque
- resp_test  out  2  always 0
- resp_len  out  2  copy of req_len
- resp_data  out  32  read data (0 for write/init)

## Operation
- Accept on rising edge with req_val && req_rdy. Array access happens at that same edge.
- Word index = req_addr[p_nwords_log+1:2]. Upper address bits are ignored, so addresses wrap modulo array size.
- Byte offset o = req_addr[1:0], n = (req_len==0 ? 4 : req_len). Only bytes o..min(o+n,4)-1 of the word are touched.
- Bytes that would spill past byte 3 are dropped. There is no access to the next word.
- Write/init: byte k of req_data goes to word byte o+k. Other bytes are unchanged. Init behaves identically to write.
- Read: word bytes o..o+n-1 are returned in resp_data bytes 0..n-1. Upper bytes are zero.
- Read-after-write: a read accepted after a write observes it. Requests commit in accept order.
- Response path: a p_latency-deep delay pipe feeds an output FIFO. Each pipe stage carries a valid bit plus type/opaque/len/data. The FIFO depth is p_latency+2.
- Occupancy counter = accepted requests whose responses are not yet consumed. It increments on accept and decrements on a resp handshake. Simultaneous accept and consume leaves it unchanged.
- req_rdy = !reset && occupancy < p_latency+2, so the FIFO can never overflow.
- The pipe never stalls. Entries advance every cycle into the FIFO.
- resp_val is asserted when the FIFO is non-empty; the FIFO head drives all resp_* fields.
- Responses are strictly in order and are never dropped or reordered.
- Array contents are not reset.

## Timing
- Reset (while asserted and the cycle after):
  - resp_val=0 and req_rdy=0 while reset is high; req_rdy=1 from the first cycle reset is low.
  - Pipe valids, FIFO pointers and occupancy are cleared to 0. resp_* data fields are don't-care while resp_val=0.
- Reset mid-operation:
  - All in-flight and queued responses are discarded. No response for them ever appears.
  - Writes already accepted remain in the array.
- Latency:
  - A request accepted at edge N produces resp_val=1 in the cycle after edge N+p_latency−1.
  - For p_latency=1, the response is visible in the cycle after acceptance.
  - This holds when the FIFO is empty and resp_rdy=1; otherwise the response waits behind earlier entries.
- Throughput: one request per cycle is sustained with resp_rdy held at 1.
- Handshake rules:
  - resp_* fields are stable while resp_val=1 and resp_rdy=0.
  - Requests presented with req_rdy=0 are ignored and have no side effects.
- Full: after p_latency+2 unconsumed accepts, req_rdy=0.
  - A resp handshake at edge M raises req_rdy in the cycle after M.
  - req_rdy is not combinationally dependent on resp_rdy.
- Empty: resp_val=0. resp_rdy is ignored.

## Test plan
- Write then read:
  - Stimulus (p_latency=1): write addr 0x200, data 0xDEADBEEF, opaque 0x11; then read 0x200 with opaque 0x22.
  - Required: write resp {type 1, opaque 0x11, data 0}, then read resp {type 0, opaque 0x22, data 0xDEADBEEF}, each one cycle after accept.
- Pipelined reads:
  - Stimulus (p_latency=3): 4 back-to-back reads of 0x200/0x204/0x208/0x20C on consecutive edges, resp_rdy=1.
  - Required: 4 consecutive resp_val cycles, in order, with opaques echoed; first response 3 cycles after the first accept.
- Backpressure:
  - Stimulus (p_latency=2): resp_rdy=0, offer 6 requests.
  - Required: exactly 4 accepted, then req_rdy=0 and FIFO head stable.
  - Then raise resp_rdy for one cycle: req_rdy=1 the next cycle and the 5th request is accepted.
- Sub-word access:
  - Stimulus: write word 0x00000000 at 0x300; write len=1 data 0xAB at 0x302; write len=2 data 0xCDEF at 0x303.
  - Required: read at 0x300 returns 0xEFAB0000 (spill byte 0xCD dropped). Read len=2 at 0x302 returns 0x0000EFAB.
- Address wrap:
  - Stimulus (p_nwords_log=8): write 0x12345678 to 0x400, then read 0x000.
  - Required: read returns 0x12345678.
- Reset mid-flight:
  - Stimulus (p_latency=3): accept a write at 0x100 and 2 reads, assert reset one cycle, then read 0x100.
  - Required: no response for the pre-reset requests. Post-reset read returns the written data. req_rdy=0 during the reset cycle.

Source files
------------

// File: rtl/imem_resp_unit.sv
// -----------------------------------------------------------------------------
// imem_resp_unit
//
// Behavioural memory responder for a 4-byte request/response stream. Requests
// are accepted over a val/rdy handshake. The word array is read or written at
// the accept edge. Responses return in order after p_latency cycles, through a
// non-stalling delay pipe that feeds an output FIFO.
//
// Parameters
//   p_latency     cycles from request accept to response valid (>= 1)
//   p_nwords_log  log2 of the array depth in 32-bit words
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   req_val/req_rdy   request handshake
//   req_type          0=read, 1=write, 2=init
//   req_opaque        tag echoed in the response
//   req_addr          byte address (wraps modulo the array size)
//   req_len           access length in bytes, 0 means 4
//   req_data          write data, LSB-aligned
//   resp_val/resp_rdy response handshake
//   resp_type/opaque/len  echoes of the request fields
//   resp_test         always 0
//   resp_data         read data (0 for write/init)
// -----------------------------------------------------------------------------
module imem_resp_unit #(
    parameter int unsigned p_latency    = 1,
    parameter int unsigned p_nwords_log = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [2:0]  req_type,
    input  logic [7:0]  req_opaque,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_data,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [2:0]  resp_type,
    output logic [7:0]  resp_opaque,
    output logic [1:0]  resp_test,
    output logic [1:0]  resp_len,
    output logic [31:0] resp_data
);

    localparam int unsigned DEPTH  = p_latency + 2;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned NWORDS = 1 << p_nwords_log;

    typedef struct packed {
        logic [2:0]  rtype;
        logic [7:0]  opaque;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    logic [31:0]             mem_q [NWORDS];
    logic [p_nwords_log-1:0] word_idx_s;
    logic [1:0]              byte_off_s;
    logic [2:0]              nbytes_s;
    logic                    is_write_s;
    logic [31:0]             rd_word_s;
    logic [31:0]             wr_shift_s;
    logic [31:0]             rd_shift_s;
    logic [31:0]             rd_data_s;
    logic [31:0]             mem_wdata_d;
    resp_t                   new_entry_s;
    logic                    req_fire_s;
    logic                    resp_fire_s;
    logic                    push_val_s;
    resp_t                   push_entry_s;
    logic                    addr_unused_s;

    resp_t              fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   occ_q, occ_d;

    // Address bits above the array index are deliberately ignored (wrap).
    assign addr_unused_s = ^req_addr[31:p_nwords_log+2];

    // Occupancy bounds pipe + FIFO contents, so the FIFO can never overflow.
    assign req_rdy     = !reset && (occ_q < CNT_W'(DEPTH));
    assign req_fire_s  = req_val && req_rdy;
    assign resp_val    = (cnt_q != CNT_W'(0));
    assign resp_fire_s = resp_val && resp_rdy;

    // Decode the request, merge write bytes and extract read bytes.
    always_comb begin
        word_idx_s  = req_addr[p_nwords_log+1:2];
        byte_off_s  = req_addr[1:0];
        nbytes_s    = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
        is_write_s  = (req_type == 3'd1) || (req_type == 3'd2);
        rd_word_s   = mem_q[word_idx_s];
        wr_shift_s  = req_data << {byte_off_s, 3'b000};
        rd_shift_s  = rd_word_s >> {byte_off_s, 3'b000};
        mem_wdata_d = rd_word_s;
        rd_data_s   = 32'd0;
        for (int k = 0; k < 4; k++) begin
            // Bytes past byte 3 simply fall off: no access to the next word.
            if ((k >= int'(byte_off_s)) && (k < int'(byte_off_s) + int'(nbytes_s))) begin
                mem_wdata_d[8*k +: 8] = wr_shift_s[8*k +: 8];
            end else begin
                mem_wdata_d[8*k +: 8] = rd_word_s[8*k +: 8];
            end
            if (k < int'(nbytes_s)) begin
                rd_data_s[8*k +: 8] = rd_shift_s[8*k +: 8];
            end else begin
                rd_data_s[8*k +: 8] = 8'd0;
            end
        end
        new_entry_s.rtype  = req_type;
        new_entry_s.opaque = req_opaque;
        new_entry_s.len    = req_len;
        new_entry_s.data   = is_write_s ? 32'd0 : rd_data_s;
    end

    // Word array write at the accept edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (req_fire_s && is_write_s) begin
            mem_q[word_idx_s] <= mem_wdata_d;
        end
    end

    // The accept edge itself counts as the first latency cycle, so only
    // p_latency-1 registered stages sit between the request and the FIFO.
    if (p_latency == 1) begin : g_no_pipe
        assign push_val_s   = req_fire_s;
        assign push_entry_s = new_entry_s;
    end else begin : g_pipe
        localparam int unsigned NST = p_latency - 1;
        logic [NST-1:0] pv_q, pv_d;
        resp_t          pe_q [NST];
        resp_t          pe_d [NST];

        // Shift the pipe one stage per cycle; it never stalls.
        always_comb begin
            pv_d[0] = req_fire_s;
            pe_d[0] = new_entry_s;
            for (int i = 1; i < NST; i++) begin
                pv_d[i] = pv_q[i-1];
                pe_d[i] = pe_q[i-1];
            end
        end

        // Pipe valid bits, cleared by reset so in-flight work is discarded.
        always_ff @(posedge clk) begin
            if (reset) begin
                pv_q <= '0;
            end else begin
                pv_q <= pv_d;
            end
        end

        // Pipe payload registers.
        always_ff @(posedge clk) begin
            for (int i = 0; i < NST; i++) begin
                pe_q[i] <= pe_d[i];
            end
        end

        assign push_val_s   = pv_q[NST-1];
        assign push_entry_s = pe_q[NST-1];
    end

    // FIFO pointer, FIFO count and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        occ_d    = occ_q;
        if (push_val_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (resp_fire_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_val_s, resp_fire_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({req_fire_s, resp_fire_s})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_W'(0);
            occ_q    <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
        end
    end

    // FIFO storage; a push never lands on a full FIFO thanks to req_rdy.
    always_ff @(posedge clk) begin
        if (push_val_s) begin
            fifo_q[wr_ptr_q] <= push_entry_s;
        end
    end

    assign resp_type   = fifo_q[rd_ptr_q].rtype;
    assign resp_opaque = fifo_q[rd_ptr_q].opaque;
    assign resp_len    = fifo_q[rd_ptr_q].len;
    assign resp_data   = fifo_q[rd_ptr_q].data;
    assign resp_test   = 2'b00;

endmodule

// File: tb/tb_imem_resp_unit.sv
// -----------------------------------------------------------------------------
// tb_imem_resp_unit
//
// Directed bench for imem_resp_unit with p_latency=2, p_nwords_log=8
// (FIFO depth 4). Inputs change 1 ns after a rising edge; outputs are sampled
// at that same point, i.e. they reflect state after the edge.
// -----------------------------------------------------------------------------
module tb_imem_resp_unit;

    localparam int unsigned LAT = 2;
    localparam int unsigned NWL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_type;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [2:0]  resp_type;
    logic [7:0]  resp_opaque;
    logic [1:0]  resp_test;
    logic [1:0]  resp_len;
    logic [31:0] resp_data;

    int n_checks = 0;
    int n_errors = 0;

    imem_resp_unit #(.p_latency(LAT), .p_nwords_log(NWL)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
        .req_opaque(req_opaque), .req_addr(req_addr), .req_len(req_len),
        .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
        .resp_opaque(resp_opaque), .resp_test(resp_test), .resp_len(resp_len),
        .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [2:0] t, input logic [7:0] op,
                            input logic [1:0] l, input logic [31:0] d);
        chk({tag, "_val"}, 64'(resp_val), 64'd1);
        chk(tag, 64'({resp_type, resp_opaque, resp_len, resp_test, resp_data}),
            64'({t, op, l, 2'b00, d}));
    endtask

    task automatic set_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                           input logic [1:0] l, input logic [31:0] d);
        req_val    = 1'b1;
        req_type   = t;
        req_opaque = op;
        req_addr   = a;
        req_len    = l;
        req_data   = d;
    endtask

    // Single isolated transaction with resp_rdy=1: invisible one cycle after
    // accept, visible the next, consumed the one after.
    task automatic xact(input string tag, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                        input logic [31:0] exp);
        set_req(t, op, a, l, d);
        chk({tag, "_rdy"}, 64'(req_rdy), 64'd1);
        tick();
        req_val = 1'b0;
        chk({tag, "_early"}, 64'(resp_val), 64'd0);
        tick();
        chk_resp(tag, t, op, l, exp);
        tick();
        chk({tag, "_drain"}, 64'(resp_val), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_val    = 1'b0;
        req_type   = 3'd0;
        req_opaque = 8'd0;
        req_addr   = 32'd0;
        req_len    = 2'd0;
        req_data   = 32'd0;
        resp_rdy   = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_rdy", 64'(req_rdy), 64'd0);
        chk("rst_val", 64'(resp_val), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_rdy_rel", 64'(req_rdy), 64'd1);

        // Write then read, back to back
        set_req(3'd1, 8'h11, 32'h200, 2'd0, 32'hDEADBEEF);
        tick();
        chk("wr_early", 64'(resp_val), 64'd0);
        set_req(3'd0, 8'h22, 32'h200, 2'd0, 32'h0);
        tick();
        chk_resp("wr_resp", 3'd1, 8'h11, 2'd0, 32'h0);
        req_val = 1'b0;
        tick();
        chk_resp("rd_resp", 3'd0, 8'h22, 2'd0, 32'hDEADBEEF);
        tick();
        chk("wr_rd_empty", 64'(resp_val), 64'd0);

        // Fill 0x204..0x20C, then four back-to-back reads
        set_req(3'd1, 8'h40, 32'h204, 2'd0, 32'h11112222);
        tick();
        chk("pl_early", 64'(resp_val), 64'd0);
        set_req(3'd2, 8'h41, 32'h208, 2'd0, 32'h33334444);
        tick();
        chk_resp("pl_w0", 3'd1, 8'h40, 2'd0, 32'h0);
        set_req(3'd1, 8'h42, 32'h20C, 2'd0, 32'h55556666);
        tick();
        chk_resp("pl_w1", 3'd2, 8'h41, 2'd0, 32'h0);
        set_req(3'd0, 8'h30, 32'h200, 2'd0, 32'h0);
        tick();
        chk_resp("pl_w2", 3'd1, 8'h42, 2'd0, 32'h0);
        set_req(3'd0, 8'h31, 32'h204, 2'd0, 32'h0);
        tick();
        chk_resp("pl_r0", 3'd0, 8'h30, 2'd0, 32'hDEADBEEF);
        set_req(3'd0, 8'h32, 32'h208, 2'd0, 32'h0);
        tick();
        chk_resp("pl_r1", 3'd0, 8'h31, 2'd0, 32'h11112222);
        set_req(3'd0, 8'h33, 32'h20C, 2'd0, 32'h0);
        chk("pl_rdy", 64'(req_rdy), 64'd1);
        tick();
        chk_resp("pl_r2", 3'd0, 8'h32, 2'd0, 32'h33334444);
        req_val = 1'b0;
        tick();
        chk_resp("pl_r3", 3'd0, 8'h33, 2'd0, 32'h55556666);
        tick();
        chk("pl_empty", 64'(resp_val), 64'd0);

        // Backpressure: depth 4, so the 5th and 6th offers are refused
        resp_rdy = 1'b0;
        set_req(3'd0, 8'h50, 32'h200, 2'd0, 32'h0);
        tick();
        chk("bp_early", 64'(resp_val), 64'd0);
        set_req(3'd0, 8'h51, 32'h200, 2'd0, 32'h0);
        chk("bp_rdy1", 64'(req_rdy), 64'd1);
        tick();
        chk_resp("bp_head0", 3'd0, 8'h50, 2'd0, 32'hDEADBEEF);
        set_req(3'd0, 8'h52, 32'h200, 2'd0, 32'h0);
        chk("bp_rdy2", 64'(req_rdy), 64'd1);
        tick();
        set_req(3'd0, 8'h53, 32'h200, 2'd0, 32'h0);
        chk("bp_rdy3", 64'(req_rdy), 64'd1);
        tick();
        chk("bp_full", 64'(req_rdy), 64'd0);
        set_req(3'd0, 8'h54, 32'h200, 2'd0, 32'h0);
        tick();
        chk("bp_full5", 64'(req_rdy), 64'd0);
        chk_resp("bp_head5", 3'd0, 8'h50, 2'd0, 32'hDEADBEEF);
        set_req(3'd0, 8'h55, 32'h200, 2'd0, 32'h0);
        tick();
        chk("bp_full6", 64'(req_rdy), 64'd0);
        chk_resp("bp_head6", 3'd0, 8'h50, 2'd0, 32'hDEADBEEF);
        set_req(3'd0, 8'h54, 32'h200, 2'd0, 32'h0);
        resp_rdy = 1'b1;
        #1;
        chk("bp_no_comb", 64'(req_rdy), 64'd0);
        tick();
        resp_rdy = 1'b0;
        chk("bp_reopen", 64'(req_rdy), 64'd1);
        chk_resp("bp_head7", 3'd0, 8'h51, 2'd0, 32'hDEADBEEF);
        tick();
        req_val = 1'b0;
        chk("bp_refull", 64'(req_rdy), 64'd0);
        resp_rdy = 1'b1;
        chk_resp("bp_d51", 3'd0, 8'h51, 2'd0, 32'hDEADBEEF);
        tick();
        chk_resp("bp_d52", 3'd0, 8'h52, 2'd0, 32'hDEADBEEF);
        tick();
        chk_resp("bp_d53", 3'd0, 8'h53, 2'd0, 32'hDEADBEEF);
        tick();
        chk_resp("bp_d54", 3'd0, 8'h54, 2'd0, 32'hDEADBEEF);
        tick();
        chk("bp_empty", 64'(resp_val), 64'd0);

        // Sub-word access: word becomes EF AB 00 00, spill byte CD dropped
        xact("sw_w0", 3'd1, 8'h60, 32'h300, 2'd0, 32'h00000000, 32'h0);
        xact("sw_w1", 3'd1, 8'h61, 32'h302, 2'd1, 32'h000000AB, 32'h0);
        xact("sw_w2", 3'd2, 8'h62, 32'h303, 2'd2, 32'h0000CDEF, 32'h0);
        xact("sw_r0", 3'd0, 8'h63, 32'h300, 2'd0, 32'h0, 32'hEFAB0000);
        xact("sw_r1", 3'd0, 8'h64, 32'h302, 2'd2, 32'h0, 32'h0000EFAB);
        xact("sw_r2", 3'd0, 8'h65, 32'h303, 2'd1, 32'h0, 32'h000000EF);
        xact("sw_r3", 3'd0, 8'h66, 32'h301, 2'd0, 32'h0, 32'h00EFAB00);

        // Address wrap: 0x400 aliases word 0
        xact("wrap_w", 3'd1, 8'h67, 32'h400, 2'd0, 32'h12345678, 32'h0);
        xact("wrap_r", 3'd0, 8'h68, 32'h000, 2'd0, 32'h0, 32'h12345678);

        // Reset mid-flight: queued responses vanish, the write survives
        resp_rdy = 1'b0;
        set_req(3'd1, 8'h70, 32'h100, 2'd0, 32'hCAFEF00D);
        tick();
        set_req(3'd0, 8'h71, 32'h100, 2'd0, 32'h0);
        tick();
        set_req(3'd0, 8'h72, 32'h100, 2'd0, 32'h0);
        tick();
        chk_resp("mr_head", 3'd1, 8'h70, 2'd0, 32'h0);
        req_val = 1'b0;
        reset   = 1'b1;
        #1;
        chk("mr_rdy_rst", 64'(req_rdy), 64'd0);
        tick();
        chk("mr_val_rst", 64'(resp_val), 64'd0);
        chk("mr_rdy_rst2", 64'(req_rdy), 64'd0);
        reset    = 1'b0;
        resp_rdy = 1'b1;
        #1;
        chk("mr_rdy_rel", 64'(req_rdy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_no_resp", 64'(resp_val), 64'd0);
        end
        xact("mr_rd", 3'd0, 8'h73, 32'h100, 2'd0, 32'h0, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
